// File: rtl/vote_pkg.sv
// Shared types and constants for the vote controller: state encoding, candidate
// count, counter/ballot widths and small button-decoding helpers.
package vote_pkg;

    localparam int NUM_CAND  = 4;
    localparam int CNT_W_DEF = 8;
    localparam int BALLOT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPEN,
        ST_BALLOT,
        ST_CAST,
        ST_CLOSED,
        ST_TALLY,
        ST_RESULT
    } state_t;

    function automatic logic [2:0] btn_count(input logic [NUM_CAND-1:0] b);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            n = n + 3'(b[i]);
        end
        return n;
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic logic [1:0] onehot_index(input logic [NUM_CAND-1:0] b);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (b[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vote_controller_if.sv
// Poll/ballot bus between the voting panel (master) and the vote controller (slave).
interface vote_controller_if
    import vote_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic                      open_poll;
    logic                      close_poll;
    logic                      voter_auth;
    logic [NUM_CAND-1:0]       btn;
    logic [NUM_CAND*CNT_W-1:0] count_in;
    logic [NUM_CAND-1:0]       vv;
    logic                      mode;
    logic                      ballot_ready;
    logic                      reject;
    logic [BALLOT_W-1:0]       ballots;
    logic [1:0]                winner;
    logic                      tie;
    logic                      result_valid;

    modport master (
        output open_poll, close_poll, voter_auth, btn, count_in,
        input  vv, mode, ballot_ready, reject, ballots, winner, tie, result_valid
    );

    modport slave (
        input  open_poll, close_poll, voter_auth, btn, count_in,
        output vv, mode, ballot_ready, reject, ballots, winner, tie, result_valid
    );

endinterface

// File: rtl/vote_tally.sv
// Sequential max/tie scanner: after a start pulse, visits one candidate per cycle
// and pulses done with the leading index and tie flag after the last one.
module vote_tally
    import vote_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_CAND*CNT_W-1:0] count_in,
    output logic                      done,
    output logic [1:0]                winner,
    output logic                      tie
);

    logic [CNT_W-1:0] cand [NUM_CAND];
    logic [CNT_W-1:0] cur;
    logic             busy_reg;
    logic [1:0]       idx_reg;
    logic [CNT_W-1:0] max_reg;
    logic [1:0]       winner_reg;
    logic             tie_reg;
    logic             done_reg;

    for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_cand
        assign cand[gi] = count_in[gi*CNT_W +: CNT_W];
    end

    assign cur = cand[idx_reg];

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_reg   <= 1'b0;
            idx_reg    <= '0;
            max_reg    <= '0;
            winner_reg <= '0;
            tie_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                busy_reg <= 1'b1;
                idx_reg  <= '0;
            end else if (busy_reg) begin
                // Lower index keeps the lead on equality; a later strict max clears tie.
                if (idx_reg == 2'd0) begin
                    max_reg    <= cur;
                    winner_reg <= 2'd0;
                    tie_reg    <= 1'b0;
                end else if (cur > max_reg) begin
                    max_reg    <= cur;
                    winner_reg <= idx_reg;
                    tie_reg    <= 1'b0;
                end else if (cur == max_reg) begin
                    tie_reg <= 1'b1;
                end
                if (idx_reg == 2'(NUM_CAND-1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
                idx_reg <= idx_reg + 2'd1;
            end
        end
    end

    assign done   = done_reg;
    assign winner = winner_reg;
    assign tie    = tie_reg;

endmodule

// File: rtl/vote_controller.sv
// Voting session FSM: poll open/close, ballot validation with counter saturation
// guard, and tally/result hand-off. Optional ballot timeout under VOTE_TIMEOUT_EN.
module vote_controller
    import vote_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    vote_controller_if.slave  bus
);

    state_t               state_reg;
    logic [NUM_CAND-1:0]  vv_reg;
    logic                 mode_reg;
    logic                 ready_reg;
    logic                 reject_reg;
    logic [BALLOT_W-1:0]  ballots_reg;
    logic [1:0]           winner_reg;
    logic                 tie_reg;
    logic                 rv_reg;

    logic [CNT_W-1:0]     cand [NUM_CAND];
    logic [2:0]           btn_n;
    logic [1:0]           sel_idx;
    logic                 sel_full;
    logic                 timeout;
    logic                 tally_start;
    logic                 tally_done;
    logic [1:0]           tally_winner;
    logic                 tally_tie;

    for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_cand
        assign cand[gi] = bus.count_in[gi*CNT_W +: CNT_W];
    end

    assign btn_n       = btn_count(bus.btn);
    assign sel_idx     = onehot_index(bus.btn);
    assign sel_full    = (cand[sel_idx] == {CNT_W{1'b1}});
    assign tally_start = (state_reg == ST_CLOSED);

`ifdef VOTE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_reg;

    // Counts cycles spent in BALLOT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clock) begin
        if (!reset || state_reg != ST_BALLOT) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    assign timeout = (state_reg == ST_BALLOT) && (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    vote_tally #(.CNT_W(CNT_W)) u_tally (
        .clock    (clock),
        .reset    (reset),
        .start    (tally_start),
        .count_in (bus.count_in),
        .done     (tally_done),
        .winner   (tally_winner),
        .tie      (tally_tie)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            vv_reg      <= '0;
            mode_reg    <= 1'b1;
            ready_reg   <= 1'b0;
            reject_reg  <= 1'b0;
            ballots_reg <= '0;
            winner_reg  <= '0;
            tie_reg     <= 1'b0;
            rv_reg      <= 1'b0;
        end else begin
            vv_reg     <= '0;
            reject_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.open_poll) begin
                        state_reg   <= ST_OPEN;
                        mode_reg    <= 1'b0;
                        ballots_reg <= '0;
                    end
                end
                ST_OPEN: begin
                    if (bus.close_poll) begin
                        state_reg <= ST_CLOSED;
                        mode_reg  <= 1'b1;
                    end else if (bus.voter_auth) begin
                        state_reg <= ST_BALLOT;
                        ready_reg <= 1'b1;
                    end
                end
                ST_BALLOT: begin
                    // close_poll is not looked at here; OPEN picks it up afterwards.
                    if (btn_n == 3'd1) begin
                        ready_reg <= 1'b0;
                        if (sel_full) begin
                            reject_reg <= 1'b1;
                            state_reg  <= ST_OPEN;
                        end else begin
                            vv_reg    <= bus.btn;
                            state_reg <= ST_CAST;
                            if (ballots_reg != {BALLOT_W{1'b1}}) begin
                                ballots_reg <= ballots_reg + 1'b1;
                            end
                        end
                    end else if (btn_n > 3'd1) begin
                        reject_reg <= 1'b1;
                    end else if (timeout) begin
                        reject_reg <= 1'b1;
                        ready_reg  <= 1'b0;
                        state_reg  <= ST_OPEN;
                    end
                end
                ST_CAST: begin
                    state_reg <= ST_OPEN;
                end
                ST_CLOSED: begin
                    state_reg <= ST_TALLY;
                end
                ST_TALLY: begin
                    if (tally_done) begin
                        state_reg  <= ST_RESULT;
                        winner_reg <= tally_winner;
                        tie_reg    <= tally_tie;
                        rv_reg     <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (bus.open_poll) begin
                        state_reg   <= ST_OPEN;
                        mode_reg    <= 1'b0;
                        ballots_reg <= '0;
                        rv_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    mode_reg  <= 1'b1;
                    ready_reg <= 1'b0;
                    rv_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vv           = vv_reg;
    assign bus.mode         = mode_reg;
    assign bus.ballot_ready = ready_reg;
    assign bus.reject       = reject_reg;
    assign bus.ballots      = ballots_reg;
    assign bus.winner       = winner_reg;
    assign bus.tie          = tie_reg;
    assign bus.result_valid = rv_reg;

endmodule

// File: tb/tb_vote_controller.sv
// Scoreboard bench for vote_controller: random ballots and polls against a
// behavioural model; a negedge monitor pops expected vv/reject/result events.
module tb_vote_controller;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    vote_controller_if #(.CNT_W(8)) bus ();

    logic [7:0] cnt [4];
    assign bus.count_in = {cnt[3], cnt[2], cnt[1], cnt[0]};

    vote_controller #(.CNT_W(8), .TIMEOUT_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] q_vv  [$];
    int         q_bal [$];
    int         q_rej [$];
    logic [2:0] q_res [$];

    int         model_ballots = 0;
    bit         mon_en = 1'b0;
    logic       rv_prev = 1'b0;
    logic [3:0] mon_ev;
    int         mon_eb;
    int         mon_tok;
    logic [2:0] mon_er;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference result: highest count, lowest index among equals, tie if shared.
    function automatic logic [2:0] ref_result();
        int mx;
        int w;
        int n;
        mx = -1; w = 0; n = 0;
        for (int i = 0; i < 4; i++) begin
            if (int'(cnt[i]) > mx) begin
                mx = int'(cnt[i]);
                w  = i;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (int'(cnt[i]) == mx) n++;
        end
        return {(n > 1), 2'(w)};
    endfunction

    function automatic int sel_of(input logic [3:0] b);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = i;
        end
        return r;
    endfunction

    // Monitor: every DUT event must match the head of its expectation queue.
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.vv !== 4'b0000) begin
                if (q_vv.size() == 0) begin
                    chk("vv_unexpected", 32'(bus.vv), 32'd0);
                end else begin
                    mon_ev = q_vv.pop_front();
                    mon_eb = q_bal.pop_front();
                    chk("vv", 32'(bus.vv), 32'(mon_ev));
                    chk("ballots_at_vv", 32'(bus.ballots), 32'(mon_eb));
                    chk("mode_at_vv", 32'(bus.mode), 32'd0);
                end
            end
            if (bus.reject !== 1'b0) begin
                if (q_rej.size() == 0) begin
                    chk("reject_unexpected", 32'(bus.reject), 32'd0);
                end else begin
                    mon_tok = q_rej.pop_front();
                    chk("reject_no_vv", 32'(bus.vv), 32'd0);
                end
            end
            if (bus.result_valid === 1'b1 && rv_prev !== 1'b1) begin
                if (q_res.size() == 0) begin
                    chk("result_unexpected", 32'(bus.result_valid), 32'd0);
                end else begin
                    mon_er = q_res.pop_front();
                    chk("winner", 32'(bus.winner), 32'(mon_er[1:0]));
                    chk("tie", 32'(bus.tie), 32'(mon_er[2]));
                    chk("mode_result", 32'(bus.mode), 32'd1);
                end
            end
        end
        rv_prev = bus.result_valid;
    end

    task automatic open_session();
        bus.open_poll = 1'b1;
        tick();
        bus.open_poll = 1'b0;
        model_ballots = 0;
        chk("mode_open", 32'(bus.mode), 32'd0);
        chk("ballots_clear", 32'(bus.ballots), 32'd0);
        chk("rv_clear", 32'(bus.result_valid), 32'd0);
    endtask

    // One voter: optional invalid multi-press first, then a single-button press.
    task automatic ballot(input logic [3:0] first, input logic [3:0] second);
        logic [3:0] b;
        b = first;
        bus.voter_auth = 1'b1;
        tick();
        bus.voter_auth = 1'b0;
        chk("ballot_ready", 32'(bus.ballot_ready), 32'd1);
        if ($countones(b) > 1) begin
            bus.btn = b;
            q_rej.push_back(1);
            tick();
            chk("stay_ballot", 32'(bus.ballot_ready), 32'd1);
            b = second;
        end
        bus.btn = b;
        if (cnt[sel_of(b)] == 8'hFF) begin
            q_rej.push_back(1);
            tick();
            bus.btn = 4'b0000;
            chk("sat_ready", 32'(bus.ballot_ready), 32'd0);
            chk("sat_mode", 32'(bus.mode), 32'd0);
        end else begin
            model_ballots = (model_ballots < 65535) ? model_ballots + 1 : 65535;
            q_vv.push_back(b);
            q_bal.push_back(model_ballots);
            tick();
            bus.btn = 4'b0000;
            tick();
            chk("open_after_cast", 32'(bus.ballot_ready), 32'd0);
        end
    endtask

    task automatic close_and_check();
        q_res.push_back(ref_result());
        bus.close_poll = 1'b1;
        tick();
        bus.close_poll = 1'b0;
        chk("mode_closed", 32'(bus.mode), 32'd1);
        repeat (5) tick();
        chk("rv_early", 32'(bus.result_valid), 32'd0);
        tick();
        chk("rv_latency", 32'(bus.result_valid), 32'd1);
        repeat (2) tick();
        chk("rv_hold", 32'(bus.result_valid), 32'd1);
    endtask

    function automatic logic [3:0] rand_onehot();
        logic [3:0] one;
        one = 4'b0001;
        return one << $urandom_range(0, 3);
    endfunction

    function automatic logic [3:0] rand_multi();
        logic [3:0] b;
        b = 4'($urandom_range(0, 15));
        while ($countones(b) < 2) b = 4'($urandom_range(0, 15));
        return b;
    endfunction

    initial begin
        bus.open_poll  = 1'b0;
        bus.close_poll = 1'b0;
        bus.voter_auth = 1'b0;
        bus.btn        = 4'b0000;
        for (int i = 0; i < 4; i++) cnt[i] = 8'd0;

        reset = 1'b0;
        repeat (3) tick();
        chk("rst_vv", 32'(bus.vv), 32'd0);
        chk("rst_mode", 32'(bus.mode), 32'd1);
        chk("rst_ready", 32'(bus.ballot_ready), 32'd0);
        chk("rst_reject", 32'(bus.reject), 32'd0);
        chk("rst_ballots", 32'(bus.ballots), 32'd0);
        chk("rst_winner", 32'(bus.winner), 32'd0);
        chk("rst_tie", 32'(bus.tie), 32'd0);
        chk("rst_rv", 32'(bus.result_valid), 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;
        tick();

        // close_poll in IDLE is ignored
        bus.close_poll = 1'b1;
        repeat (2) tick();
        bus.close_poll = 1'b0;
        chk("idle_close_ignored", 32'(bus.mode), 32'd1);

        open_session();
        ballot(4'b0100, 4'b0000);
        chk("ballots_one", 32'(bus.ballots), 32'd1);
        ballot(4'b0011, 4'b0001);
        cnt[1] = 8'hFF;
        ballot(4'b0010, 4'b0000);
        cnt[1] = 8'd0;
        chk("ballots_after_sat", 32'(bus.ballots), 32'(model_ballots));

        // close_poll raised mid-ballot is deferred until the ballot resolves
        cnt[0] = 8'd5; cnt[1] = 8'd30; cnt[2] = 8'd30; cnt[3] = 8'd10;
        q_res.push_back(ref_result());
        bus.voter_auth = 1'b1;
        tick();
        bus.voter_auth = 1'b0;
        bus.close_poll = 1'b1;
        repeat (2) tick();
        chk("deferred_close", 32'(bus.ballot_ready), 32'd1);
        model_ballots++;
        q_vv.push_back(4'b1000);
        q_bal.push_back(model_ballots);
        bus.btn = 4'b1000;
        tick();
        bus.btn = 4'b0000;
        repeat (10) tick();
        bus.close_poll = 1'b0;
        chk("deferred_result", 32'(bus.result_valid), 32'd1);

        open_session();
        close_and_check();

        // Random sessions
        for (int s = 0; s < 3; s++) begin
            open_session();
            for (int v = 0; v < 10; v++) begin
                for (int i = 0; i < 4; i++)
                    cnt[i] = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
                if ($urandom_range(0, 3) == 0) ballot(rand_multi(), rand_onehot());
                else ballot(rand_onehot(), 4'b0000);
            end
            chk("ballots_session", 32'(bus.ballots), 32'(model_ballots));
            for (int i = 0; i < 4; i++)
                cnt[i] = (s == 1) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255));
            close_and_check();
        end

        // Reset while in CAST aborts without a trailing vv
        open_session();
        for (int i = 0; i < 4; i++) cnt[i] = 8'd0;
        bus.voter_auth = 1'b1;
        tick();
        bus.voter_auth = 1'b0;
        q_vv.push_back(4'b0001);
        q_bal.push_back(1);
        bus.btn = 4'b0001;
        tick();
        bus.btn = 4'b0000;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("cast_rst_vv", 32'(bus.vv), 32'd0);
        chk("cast_rst_ballots", 32'(bus.ballots), 32'd0);
        chk("cast_rst_mode", 32'(bus.mode), 32'd1);
        tick();
        chk("cast_rst_no_vv", 32'(bus.vv), 32'd0);

`ifdef VOTE_TIMEOUT_EN
        open_session();
        bus.voter_auth = 1'b1;
        tick();
        bus.voter_auth = 1'b0;
        q_rej.push_back(1);
        repeat (3) tick();
        chk("timeout_waiting", 32'(bus.ballot_ready), 32'd1);
        tick();
        chk("timeout_reject", 32'(bus.reject), 32'd1);
        chk("timeout_open", 32'(bus.ballot_ready), 32'd0);
        chk("timeout_mode", 32'(bus.mode), 32'd0);
`endif

        repeat (4) tick();
        chk("q_vv_drained", 32'(q_vv.size()), 32'd0);
        chk("q_rej_drained", 32'(q_rej.size()), 32'd0);
        chk("q_res_drained", 32'(q_res.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vote_controller.md
VOTE_CONTROLLER -- requirements
Module: vote_controller

Interface
REQ-001 Parameter CNT_W, default 8, width of each candidate count.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, ballot timeout in clocks (used only with VOTE_TIMEOUT_EN).
REQ-003 Single clock, "clock"; reset, "reset", is synchronous and active-low.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 open_poll  input  1  level; start a session.
REQ-007 close_poll  input  1  level; end the session.
REQ-008 voter_auth  input  1  one voter authorised; accepted only in OPEN.
REQ-009 btn  input  4  candidate buttons, bit i = candidate i+1.
REQ-010 count_in  input  4*CNT_W  current counter values, candidate 1 in LSBs.
REQ-011 vv  output  4  one-hot valid-vote pulse to the counter block.
REQ-012 mode  output  1  counter mode: 0 = counting enabled, 1 = locked.
REQ-013 ballot_ready  output  1  high while a voter may press a button.
REQ-014 reject  output  1  one-cycle pulse on an invalid ballot.
REQ-015 ballots  output  16  number of accepted ballots this session.
REQ-016 winner  output  2  index of the leading candidate (0..3), valid in RESULT.
REQ-017 tie  output  1  leading count shared by two or more candidates, valid in RESULT.
REQ-018 result_valid  output  1  high in RESULT.

Function
REQ-019 States: IDLE, OPEN, BALLOT, CAST, CLOSED, TALLY, RESULT.
REQ-020 IDLE->OPEN on open_poll; close_poll in IDLE is ignored.
REQ-021 OPEN->BALLOT on voter_auth; OPEN->CLOSED on close_poll; close_poll wins if both are high.
REQ-022 BALLOT: exactly one btn bit set -> CAST; two or more bits set -> reject pulse, stay in BALLOT; zero bits -> wait.
REQ-023 BALLOT: close_poll is deferred until the ballot resolves; it is not lost, because it is level-sensitive and re-checked in OPEN.
REQ-024 BALLOT: if the selected count_in equals 2^CNT_W-1, pulse reject and return to OPEN; no vv is issued (saturation guard).
REQ-025 CAST: vv is one-hot for exactly one cycle; ballots increments, saturating at 16'hFFFF; next state is OPEN.
REQ-026 mode = 0 in OPEN, BALLOT and CAST; mode = 1 in all other states; vv = 0 outside CAST.
REQ-027 ballot_ready = 1 only in BALLOT.
REQ-028 CLOSED->TALLY after one cycle, letting the counter settle.
REQ-029 TALLY scans candidates 0..3, one per cycle (4 cycles), keeping the strict maximum; on an equal maximum, the lower index is kept and tie is set.
REQ-030 TALLY->RESULT; winner, tie and result_valid hold in RESULT.
REQ-031 RESULT->OPEN on open_poll; ballots clears to 0 on entering OPEN from IDLE or RESULT.
REQ-032 Latency: voter_auth accepted at edge N gives ballot_ready at N+1; a valid button sampled at edge M gives vv at M+1.

Reset
REQ-033 With reset low at a clock edge: state = IDLE, vv = 0, mode = 1, ballot_ready = 0, reject = 0, ballots = 0, winner = 0, tie = 0, result_valid = 0.
REQ-034 Reset in BALLOT or CAST aborts the ballot; no vv pulse appears after the reset edge.

Configuration
REQ-035 Macro VOTE_TIMEOUT_EN.
- Defined: a BALLOT lasting TIMEOUT_CYCLES without resolving pulses reject and returns to OPEN; the timer restarts on each BALLOT entry.
- Undefined: BALLOT waits indefinitely; no timer is synthesised.

Structure
REQ-036 Package vote_pkg holds the state enum, NUM_CAND = 4, default CNT_W and the ballots width.
REQ-037 Sub-module vote_tally contains the sequential max/tie scanner; the FSM stays in vote_controller.

Verification
REQ-038 open_poll, voter_auth, btn = 4'b0100 -> vv = 4'b0100 for one cycle, ballots = 1, mode = 0.
REQ-039 In BALLOT, btn = 4'b0011 -> reject pulse, no vv; then btn = 4'b0001 -> vv = 4'b0001.
REQ-040 count_in candidate 2 = 8'hFF, btn = 4'b0010 -> reject, no vv, state OPEN.
REQ-041 count_in = {10, 30, 30, 5} (candidates 4..1), close_poll -> after 6 cycles result_valid = 1, winner = 1, tie = 1, mode = 1.
REQ-042 Reset low during CAST -> vv = 0 next cycle, state IDLE, ballots = 0.
REQ-043 VOTE_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4, no button press -> reject after 4 cycles, then OPEN.
